regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard. It is the successor to the single-write, two-read register file.
- Serves the pipelined core: NRD combinational read ports, NWR synchronous write ports with fixed priority, and a busy-bit scoreboard that decode uses for RAW hazard detection.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_rs_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  read data for port k.
- o_rs_busy  out  NRD  register addressed by read port k has a pending write.
- i_rd_wren  in  NWR  write enable per write port.
- i_rd_addr  in  NWR*AW  write address per write port.
- i_rd_data  in  NWR*XLEN  write data per write port.
- i_alloc_vld  in  1  mark register i_alloc_addr as pending (producer issued).
- i_alloc_addr  in  AW  register to mark busy.
- i_flush  in  1  clear all busy bits; register contents are kept.
- o_busy_vec  out  NREG  full scoreboard; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset: when i_rst is high at a rising edge, all NREG registers become 0 and all busy bits become 0. i_rst overrides every write, alloc and flush in the same cycle.
- Outputs during and after reset: o_rs_data = 0 and o_rs_busy = 0 for every address. o_busy_vec = 0.
- Read ports: combinational, zero latency.
  - Address 0 always returns 0 and busy = 0.
  - Any other address returns the stored value (see BYPASS_EN for same-cycle forwarding).
- Write ports: a write takes effect at the rising edge when i_rd_wren[j] = 1 and i_rd_addr[j] != 0. Writes to address 0 are discarded.
- Write collision: if both write ports target the same nonzero address in one cycle, port NWR-1 wins. Port 0 data is lost and no error is flagged.
- Scoreboard, per nonzero register r, evaluated at each rising edge in this priority order:
  1. i_rst: busy[r] <= 0.
  2. i_flush: busy[r] <= 0. Any alloc in the same cycle is ignored.
  3. i_alloc_vld and i_alloc_addr == r: busy[r] <= 1. This wins over a simultaneous write to r, because the new producer is now outstanding.
  4. Any enabled write to r: busy[r] <= 0.
  5. Otherwise busy[r] holds.
- Alloc to address 0 has no effect.
- A write to a register that is not busy still updates its data and leaves busy at 0.
- o_rs_busy[k] reflects the registered busy bit for i_rs_addr[k] (the state before the current edge).
- Address widths: if NREG is not a power of two, out-of-range addresses read 0 and not-busy, and writes to them are dropped. Power-of-two NREG is the supported configuration.
- No internal state machine beyond the register array and busy vector. Both are updated every cycle; no stalls.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-through forwarding.
  - If an enabled write port targets the same nonzero address as read port k in the same cycle, o_rs_data[k] returns that write's data combinationally. Port priority matches the write-collision rule.
  - o_rs_busy[k] is forced to 0 for that port in that cycle, unless a same-cycle alloc also targets the address.
- Not defined: reads return the pre-edge stored value. The written value becomes visible the cycle after the write, and busy clears at the edge.

Test Plan:
1. Reset: set i_rst=1 for 2 cycles after all registers have been written with 0xFFFFFFFF, then release -> every read port returns 0, o_busy_vec=0.
2. x0 guard: write 0xDEADBEEF to address 0 via both ports, then alloc address 0 -> reading address 0 gives 0, busy=0, o_busy_vec[0]=0.
3. Write collision: port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle -> next cycle x5 reads 0x22222222.
4. Scoreboard sequence:
   - Alloc x7 -> next cycle o_rs_busy for x7 = 1.
   - Alloc x7 and write x7=0xA5 in the same cycle -> x7 stays busy and reads 0xA5.
   - Write x7=0x5A -> busy=0 and x7 reads 0x5A.
5. Flush: alloc x3, x4, x9 over 3 cycles, then i_flush=1 with a simultaneous alloc of x10 -> o_busy_vec=0. x3, x4 and x9 keep their prior data.
6. Bypass: in the same cycle, write x12=0x12345678 and read x12 on port 1, with x12 previously 0 and busy.
   - With REGFILE_MP_BYPASS_EN: port 1 reads 0x12345678 with busy=0 that cycle.
   - Without it: port 1 reads 0 with busy=1 that cycle, then 0x12345678 with busy=0 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-write busy scoreboard
//
// Purpose: NRD combinational read ports, NWR synchronous write ports (highest
// numbered port wins on collision), and a busy bit per register that decode
// uses for RAW hazard detection. Register 0 reads as zero and is never busy.
//
// Optional feature macro: REGFILE_MP_BYPASS_EN (same-cycle write-through
// forwarding onto the read ports). Undefined: reads see pre-edge state.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high; clears data and busy bits
//   i_rs_addr    NRD read addresses, port k at [k*AW +: AW]
//   o_rs_data    NRD read data, port k at [k*XLEN +: XLEN]
//   o_rs_busy    NRD busy flags for the addressed registers
//   i_rd_wren    NWR write enables
//   i_rd_addr    NWR write addresses
//   i_rd_data    NWR write data
//   i_alloc_vld  mark i_alloc_addr busy (producer issued)
//   i_alloc_addr register to mark busy
//   i_flush      clear all busy bits, data kept
//   o_busy_vec   full scoreboard, bit 0 always 0

module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [NWR-1:0]      i_rd_wren,
  input  logic [NWR*AW-1:0]   i_rd_addr,
  input  logic [NWR*XLEN-1:0] i_rd_data,
  input  logic                i_alloc_vld,
  input  logic [AW-1:0]       i_alloc_addr,
  input  logic                i_flush,
  output logic [NREG-1:0]     o_busy_vec
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW-1:0]   wr_addr [NWR];
  logic [NWR-1:0]  wr_ok;
  logic [AW-1:0]   rd_addr [NRD];

  // Nonzero and inside the implemented register range (matters only when
  // NREG is not a power of two).
  function automatic logic valid_addr(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_L) && (a != '0);
  endfunction

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_addr[j] = i_rd_addr[j*AW +: AW];
      wr_ok[j]   = i_rd_wren[j] && valid_addr(wr_addr[j]);
    end
    for (int k = 0; k < NRD; k++) begin
      rd_addr[k] = i_rs_addr[k*AW +: AW];
    end
  end

  // Scoreboard next state: later assignments take priority, so the order
  // below is write-clear, then alloc-set, then flush.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) busy_d[wr_addr[j]] = 1'b0;
    end
    if (i_alloc_vld && valid_addr(i_alloc_addr)) busy_d[i_alloc_addr] = 1'b1;
    if (i_flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      busy_q <= busy_d;
      // Ascending port order makes the highest-numbered port win a collision.
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) regs[wr_addr[j]] <= i_rd_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (valid_addr(rd_addr[k])) begin
        o_rs_data[k*XLEN +: XLEN] = regs[rd_addr[k]];
        o_rs_busy[k]              = busy_q[rd_addr[k]];
`ifdef REGFILE_MP_BYPASS_EN
        // Forwarding is suppressed while reset is asserted: the write is
        // going to be discarded at this edge.
        if (!i_rst) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j] && (wr_addr[j] == rd_addr[k])) begin
              o_rs_data[k*XLEN +: XLEN] = i_rd_data[j*XLEN +: XLEN];
              o_rs_busy[k] = i_alloc_vld && (i_alloc_addr == rd_addr[k]);
            end
          end
        end
`endif
      end
    end
  end

  assign o_busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (table, sequences, random vs model)

module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  ra [2];
  logic [1:0]  wren;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        alloc;
  logic [4:0]  aa;
  logic        flush;

  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] busy_vec;

  assign rs_addr = {ra[1], ra[0]};
  assign rd_addr = {wa[1], wa[0]};
  assign rd_data = {wd[1], wd[0]};

  regfile_mp dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rs_addr(rs_addr),
    .o_rs_data(rs_data),
    .o_rs_busy(rs_busy),
    .i_rd_wren(wren),
    .i_rd_addr(rd_addr),
    .i_rd_data(rd_data),
    .i_alloc_vld(alloc),
    .i_alloc_addr(aa),
    .i_flush(flush),
    .o_busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: architectural registers and busy flags as plain arrays.
  logic [31:0] m_reg [32];
  bit          m_busy [32];

  task automatic model_commit();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_reg[r] = 0; m_busy[r] = 0; end
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit hit0, hit1;
        hit0 = wren[0] && (wa[0] == 5'(r));
        hit1 = wren[1] && (wa[1] == 5'(r));
        if (hit1) m_reg[r] = wd[1];
        else if (hit0) m_reg[r] = wd[0];
        if (flush) m_busy[r] = 0;
        else if (alloc && aa == 5'(r)) m_busy[r] = 1;
        else if (hit0 || hit1) m_busy[r] = 0;
      end
    end
  endtask

  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    d = 0;
    b = 0;
    if (a != 0) begin
      d = m_reg[a];
      b = m_busy[a];
      if (BYP && !rst) begin
        for (int j = 0; j < 2; j++) begin
          if (wren[j] && wa[j] == a) begin
            d = wd[j];
            b = alloc && (aa == a);
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_bv();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren = 0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    alloc = 0; aa = 0; flush = 0;
  endtask

  typedef struct {
    logic [1:0]  wren;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        alloc;
    logic [4:0]  aa;
    logic        flush;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic        eb0, eb1;
    logic [31:0] ebv;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
    input logic [4:0] a1, input logic [31:0] d1,
    input logic al, input logic [4:0] ala, input logic fl,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] e0, input logic b0, input logic [31:0] e1, input logic b1,
    input logic [31:0] bv);
    vec_t v;
    v.wren = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.alloc = al; v.aa = ala; v.flush = fl; v.ra0 = r0; v.ra1 = r1;
    v.ed0 = e0; v.eb0 = b0; v.ed1 = e1; v.eb1 = b1; v.ebv = bv;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        b;

    // x0 guard
    tbl[0]  = mk(2'b11, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // write collision on x5
    tbl[3]  = mk(2'b11, 5, 32'h11111111, 5, 32'h22222222, 0, 0, 0, 5, 0,
                 BYP ? 32'h22222222 : 32'h0, 0, 0, 0, 0);
    tbl[4]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'h22222222, 0, 32'h22222222, 0, 0);
    // scoreboard on x7
    tbl[5]  = mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0, 32'h80);
    tbl[7]  = mk(2'b01, 7, 32'hA5, 0, 0, 1, 7, 0, 7, 0, BYP ? 32'hA5 : 32'h0, 1, 0, 0, 32'h80);
    tbl[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'hA5, 1, 0, 0, 32'h80);
    tbl[9]  = mk(2'b10, 0, 0, 7, 32'h5A, 0, 0, 0, 7, 0,
                 BYP ? 32'h5A : 32'hA5, BYP ? 1'b0 : 1'b1, 0, 0, 32'h80);
    tbl[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h5A, 0, 0, 0, 0);
    // flush with simultaneous alloc
    tbl[11] = mk(2'b11, 3, 32'h33, 4, 32'h44, 0, 0, 0, 3, 4,
                 BYP ? 32'h33 : 32'h0, 0, BYP ? 32'h44 : 32'h0, 0, 0);
    tbl[12] = mk(2'b01, 9, 32'h99, 0, 0, 1, 3, 0, 3, 4, 32'h33, 0, 32'h44, 0, 0);
    tbl[13] = mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 3, 9, 32'h33, 1, 32'h99, 0, 32'h8);
    tbl[14] = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 3, 4, 32'h33, 1, 32'h44, 1, 32'h18);
    tbl[15] = mk(2'b00, 0, 0, 0, 0, 1, 10, 1, 9, 10, 32'h99, 1, 0, 0, 32'h218);
    tbl[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 4, 32'h33, 0, 32'h44, 0, 0);
    tbl[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 10, 32'h99, 0, 0, 0, 0);
    // same-cycle write/read of a busy register
    tbl[18] = mk(2'b00, 0, 0, 0, 0, 1, 12, 0, 12, 12, 0, 0, 0, 0, 0);
    tbl[19] = mk(2'b01, 12, 32'h12345678, 0, 0, 0, 0, 0, 0, 12, 0, 0,
                 BYP ? 32'h12345678 : 32'h0, BYP ? 1'b0 : 1'b1, 32'h1000);
    tbl[20] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 12, 32'h12345678, 0, 32'h12345678, 0, 0);

    // Power-on reset
    idle();
    ra[0] = 0; ra[1] = 31;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("por_x31_data", rs_data[63:32], 0);
    chk("por_busy", {30'd0, rs_busy}, 0);
    chk("por_busy_vec", busy_vec, 0);

    // Fill every register with all-ones, allocating along the way
    for (int i = 0; i < 16; i++) begin
      wren = 2'b11; wa[0] = 5'(2*i); wa[1] = 5'(2*i+1);
      wd[0] = 32'hFFFFFFFF; wd[1] = 32'hFFFFFFFF;
      alloc = 1; aa = 5'(i + 17);
      tick();
    end
    idle();
    ra[0] = 30; ra[1] = 31;
    #1;
    chk("fill_x30", rs_data[31:0], 32'hFFFFFFFF);
    chk("fill_x31", rs_data[63:32], 32'hFFFFFFFF);
    chk("fill_busy_vec", busy_vec, model_bv());

    // Reset for two cycles with a write and alloc pending: reset must win
    rst = 1; wren = 2'b01; wa[0] = 1; wd[0] = 32'h5; alloc = 1; aa = 2;
    tick();
    tick();
    rst = 0;
    idle();
    #1;
    chk("rst_busy_vec", busy_vec, 0);
    for (int a = 0; a < 32; a += 2) begin
      ra[0] = 5'(a); ra[1] = 5'(a + 1);
      #1;
      chk($sformatf("rst_data_x%0d", a), rs_data[31:0], 0);
      chk($sformatf("rst_data_x%0d", a + 1), rs_data[63:32], 0);
      chk($sformatf("rst_busy_x%0d_x%0d", a, a + 1), {30'd0, rs_busy}, 0);
    end

    // Table-driven directed vectors
    for (int i = 0; i < 21; i++) begin
      wren = tbl[i].wren; wa[0] = tbl[i].wa0; wa[1] = tbl[i].wa1;
      wd[0] = tbl[i].wd0; wd[1] = tbl[i].wd1;
      alloc = tbl[i].alloc; aa = tbl[i].aa; flush = tbl[i].flush;
      ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
      #1;
      chk($sformatf("vec%0d_rd0", i), rs_data[31:0], tbl[i].ed0);
      chk($sformatf("vec%0d_rd1", i), rs_data[63:32], tbl[i].ed1);
      chk($sformatf("vec%0d_busy", i), {30'd0, rs_busy}, {30'd0, tbl[i].eb1, tbl[i].eb0});
      chk($sformatf("vec%0d_busy_vec", i), busy_vec, tbl[i].ebv);
      tick();
    end
    idle();

    // Randomised traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      alloc = $urandom_range(0, 1);
      wren  = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wa[j] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd[j] = $urandom;
        ra[j] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      aa = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      #1;
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          model_read(ra[k], d, b);
          chk($sformatf("rand%0d_rd%0d_x%0d", c, k, ra[k]), rs_data[k*32 +: 32], d);
          chk($sformatf("rand%0d_busy%0d_x%0d", c, k, ra[k]), {31'd0, rs_busy[k]}, {31'd0, b});
        end
        chk($sformatf("rand%0d_busy_vec", c), busy_vec, model_bv());
      end
      tick();
    end
    rst = 0;
    idle();
    #1;
    chk("final_busy_vec", busy_vec, model_bv());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
